// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
// Module      : irq_sched
// Description : Programmable interrupt controller / scheduler. Latches device
//               requests (edge or level per source), gates them with a global
//               enable and per-source mask into a registered HWInt vector, and
//               reports a "next to service" source ID (fixed or round-robin)
//               through a four-word register window on the peripheral bus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1     system clock, rising edge
//   reset      in   1     synchronous active-high reset, clears all state
//   i_sel      in   1     register-window select
//   i_addr     in   2     word offset (0 CTRL, 1 MASK, 2 MODE, 3 PEND)
//   i_we       in   1     write strobe, qualified by i_sel
//   i_wd       in   32    write data
//   o_rd       out  32    read data, combinational from state and i_addr
//   i_irq_src  in   NSRC  raw device interrupt lines
//   o_hw_int   out  NSRC  registered interrupt vector (bit i -> HWInt[i+2])
// ============================================================================
module irq_sched #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_sel,
  input  logic [1:0]      i_addr,
  input  logic            i_we,
  input  logic [31:0]     i_wd,
  output logic [31:0]     o_rd,
  input  logic [NSRC-1:0] i_irq_src,
  output logic [NSRC-1:0] o_hw_int
);

  localparam logic [1:0] C_ADDR_CTRL = 2'd0;
  localparam logic [1:0] C_ADDR_MASK = 2'd1;
  localparam logic [1:0] C_ADDR_MODE = 2'd2;
  localparam logic [1:0] C_ADDR_PEND = 2'd3;

  logic            r_gie;
  logic            r_rr;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] r_hw_int;
  logic [2:0]      r_ptr;

  logic            w_wr;
  logic            w_w1c;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_elig;
  logic [2:0]      w_start;
  logic [3:0]      w_scan;
  logic [2:0]      w_id;
  logic            w_id_vld;
  logic            w_adv;
  logic [2:0]      w_ptr_nxt;
  logic            w_unused;

  assign w_wr   = i_sel & i_we;
  assign w_w1c  = w_wr & (i_addr == C_ADDR_PEND);
  assign w_rise = i_irq_src & ~r_src_q;
  assign w_clr  = w_w1c ? i_wd[NSRC-1:0] : '0;

  // Edge sources: a new rising edge beats a same-cycle clear.
  // Level sources: pending simply mirrors the line, so W1C has no effect.
  assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) |
                      (~r_mode & i_irq_src);

  // ID selection ignores GIE so software can poll with interrupts disabled.
  assign w_elig  = r_pend & r_mask;
  assign w_start = r_rr ? r_ptr : 3'd0;

  // Circular scan starting at w_start; first eligible hit wins.
  always_comb begin
    w_id     = 3'd0;
    w_id_vld = 1'b0;
    w_scan   = 4'd0;
    for (int k = 0; k < NSRC; k++) begin
      w_scan = {1'b0, w_start} + 4'(k);
      if (w_scan >= 4'(NSRC)) begin
        w_scan = w_scan - 4'(NSRC);
      end
      if (!w_id_vld && w_elig[w_scan[2:0]]) begin
        w_id_vld = 1'b1;
        w_id     = w_scan[2:0];
      end
    end
  end

  // Round-robin pointer moves past the serviced source only when software
  // clears exactly the source the scheduler is currently presenting.
  assign w_adv     = r_rr & w_id_vld & w_clr[w_id];
  assign w_ptr_nxt = (w_id == 3'(NSRC-1)) ? 3'd0 : w_id + 3'd1;

  always_comb begin
    o_rd = 32'd0;
    case (i_addr)
      C_ADDR_CTRL: o_rd = {30'd0, r_rr, r_gie};
      C_ADDR_MASK: o_rd = {{(32-NSRC){1'b0}}, r_mask};
      C_ADDR_MODE: o_rd = {{(32-NSRC){1'b0}}, r_mode};
      default:     o_rd = {w_id_vld, 12'd0, w_id, {(16-NSRC){1'b0}}, r_pend};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gie    <= 1'b0;
      r_rr     <= 1'b0;
      r_mask   <= '0;
      r_mode   <= '0;
      r_pend   <= '0;
      r_src_q  <= '0;
      r_hw_int <= '0;
      r_ptr    <= 3'd0;
    end else begin
      r_src_q  <= i_irq_src;
      r_pend   <= w_pend_nxt;
      r_hw_int <= r_pend & r_mask & {NSRC{r_gie}};
      if (w_adv) begin
        r_ptr <= w_ptr_nxt;
      end
      if (w_wr) begin
        case (i_addr)
          C_ADDR_CTRL: begin
            r_gie <= i_wd[0];
            r_rr  <= i_wd[1];
          end
          C_ADDR_MASK: r_mask <= i_wd[NSRC-1:0];
          C_ADDR_MODE: r_mode <= i_wd[NSRC-1:0];
          default: ;
        endcase
      end
    end
  end

  assign o_hw_int = r_hw_int;

  // Upper write-data bits have no storage behind them.
  assign w_unused = ^i_wd[31:NSRC];

endmodule
`default_nettype wire

// File: doc/irq_sched.md
# irq_sched

Programmable interrupt controller and scheduler between the peripheral interrupt lines and the CPU's six hardware interrupt inputs (HWInt[7:2]). It latches device requests (edge or level per source), applies a global enable and per-source mask, and drives the registered interrupt vector consumed by CP0. It also reports a single "next to service" source ID, chosen by fixed or round-robin priority, through a memory-mapped register window on the peripheral bus (bridge side, M-stage timing).

## Interface
- NSRC, 6, number of interrupt sources; must equal the HWInt width (6).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- sel  in  1  register-window select from the bridge address decode.
- addr  in  2  word offset within the window (the CPU address bits [3:2]).
- we  in  1  write strobe; effective only when sel=1.
- wd  in  32  write data.
- rd  out  32  read data; combinational from current register state and addr; driven regardless of sel.
- irq_src  in  NSRC  raw device interrupt lines, synchronous to clk.
- hw_int  out  NSRC  registered interrupt vector to CP0 (bit i maps to HWInt[i+2]).

## Operation
- Register map by addr. Unused bits read 0 and ignore writes.
  - 0 CTRL: [0] GIE (global enable), [1] RR (1 = round-robin, 0 = fixed priority); read/write.
  - 1 MASK: [5:0] per-source enable; read/write.
  - 2 MODE: [5:0] 1 = edge-triggered, 0 = level; read/write.
  - 3 PEND: read returns [5:0] pending bits, [18:16] ID index, [31] ID valid. A write is write-1-to-clear (W1C) on pending bits whose source is in edge mode. Writes to level-mode bits are ignored.
- src_q: per-source register holding irq_src from the previous edge.
- Edge source i: PEND[i] sets when irq_src[i]=1 and src_q[i]=0. It clears on a W1C write of bit i. If set and clear occur in the same cycle, set wins.
- Level source i: PEND[i] <= irq_src[i] every cycle.
- Mode change:
  - level to edge: the PEND bit keeps its current value until cleared.
  - edge to level: the PEND bit follows the level from the next edge.
- hw_int <= PEND & MASK & {NSRC{GIE}}, registered every cycle.
- ID selection is combinational over eligible = PEND & MASK (GIE ignored).
  - Fixed mode: the lowest-numbered eligible source.
  - RR mode: the first eligible source scanning upward from ptr, wrapping 5 to 0.
  - ID valid = |eligible. When valid=0, the index field reads 0.
- ptr (3 bits, range 0..5):
  - In RR mode, a W1C write whose data clears the bit equal to the current valid ID advances ptr to ID+1, with 5 wrapping to 0.
  - In fixed mode ptr holds its value.
  - Writes that clear other bits do not move ptr.

## Timing
- Reset values:
  - rd follows registers, so it reads 0 at all offsets.
  - hw_int=0; CTRL=0, MASK=0, MODE=0 (all level), PEND=0, ptr=0, src_q=0.
- Reset has priority over any same-cycle write or source event.
- Reset mid-operation discards all pending state.
- Because src_q resets to 0, an edge-mode source still high after reset sets PEND on the first edge after reset deasserts. This only applies once MODE has been written.
- Latency, with irq_src rising before edge k:
  - PEND set at edge k.
  - hw_int asserted at edge k+1, given the source is masked-in and GIE=1.
- Register writes take effect at the edge where we & sel = 1.
  - A MASK, GIE or W1C write changes hw_int at the following edge (one-cycle lag).
  - Readback in the cycle after the write shows the new value.
- A read in the same cycle as a write returns the pre-write value.

## Test plan
- Reset and defaults: assert reset 2 cycles with irq_src=6'h3F.
  - Expect rd=0 at all offsets and hw_int=0 while reset is high.
  - After release with MODE=0: PEND=6'h3F one edge later, hw_int still 0 (MASK=0).
- Edge capture and W1C:
  - Setup: MODE=3F, MASK=3F, GIE=1.
  - Stimulus: pulse irq_src[2] for 1 cycle.
  - Expect PEND=04 next edge and hw_int=04 one edge later.
  - Then write PEND=04: PEND=0, and hw_int=0 one edge later.
- Set/clear collision: edge source 1 rises in the same cycle as a W1C of bit 1.
  - Expect PEND[1]=1 (set wins).
- Level mode: irq_src[4] held high; write PEND=10.
  - Expect PEND[4] stays 1. Drop the source: PEND[4]=0 next edge.
- Round-robin:
  - Setup: RR=1, MODE=3F, sources 0, 3 and 5 pending.
  - Expected ID sequence: 0 (ptr 0) → clear 0, ID=3 → clear 3, ID=5 → clear 5, ptr wraps to 0.
  - In fixed mode with 3 and 5 pending, ID=3 repeatedly.
- GIE gating: PEND=3F, MASK=2A, GIE=0.
  - Expect hw_int=0 while ID valid reads 1 with index 1.
  - Set GIE=1: hw_int=2A one edge later.
